// File: rtl/back_icon_channel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : back_icon_channel_arbiter_pkg
// Purpose  : Shared sizes, types and helpers for the icon channel arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package back_icon_channel_arbiter_pkg;

    localparam int NUM_ICON_CHANNELS   = 4;
    localparam int NUM_REQUESTERS      = 4;
    localparam int NUM_EXEC_UNITS      = 4;
    localparam int LOG2_NUM_EXEC_UNITS = 2;
    localparam int RECV_W              = 2 * NUM_EXEC_UNITS + 2;
    localparam int ADDR_W              = LOG2_NUM_EXEC_UNITS;
    localparam int RR_W                = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    typedef logic [ADDR_W-1:0] type_exec_unit_addr;

    typedef struct packed {
        logic                          receiver_mxreg;
        logic                          receiver_str;
        logic [2*NUM_EXEC_UNITS-1:0]   eus;
    } type_icon_receivers_list;

    typedef struct packed {
        type_exec_unit_addr      src_addr;
        type_icon_receivers_list receivers;
    } type_icon_arb_req;

    // Round-robin position offset places past base, wrapping at NUM_REQUESTERS.
    function automatic logic [RR_W-1:0] rr_index(input logic [RR_W-1:0] base, input int offset);
        int sum;
        sum = (int'(base) + offset) % NUM_REQUESTERS;
        return RR_W'(sum);
    endfunction

endpackage
`default_nettype wire

// File: rtl/back_icon_channel_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : back_icon_channel_arbiter_if
// Purpose  : Requester and channel-fabric signals of the icon channel arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface back_icon_channel_arbiter_if;
    import back_icon_channel_arbiter_pkg::*;

    logic [NUM_REQUESTERS-1:0]                 req_valid_i;
    logic [NUM_REQUESTERS-1:0][ADDR_W-1:0]     req_src_addr_i;
    logic [NUM_REQUESTERS-1:0][RECV_W-1:0]     req_receivers_i;
    logic [NUM_REQUESTERS-1:0]                 req_ready_o;
    logic [NUM_ICON_CHANNELS-1:0][ADDR_W-1:0]  ch_src_addr_o;
    logic [NUM_ICON_CHANNELS-1:0][RECV_W-1:0]  ch_receiver_list_o;
    logic [NUM_ICON_CHANNELS-1:0][RECV_W-1:0]  ch_success_i;
    logic [NUM_ICON_CHANNELS-1:0]              ch_busy_o;
    logic [NUM_ICON_CHANNELS-1:0]              ch_timeout_o;

    modport slave (
        input  req_valid_i, req_src_addr_i, req_receivers_i, ch_success_i,
        output req_ready_o, ch_src_addr_o, ch_receiver_list_o, ch_busy_o, ch_timeout_o
    );

    modport master (
        output req_valid_i, req_src_addr_i, req_receivers_i, ch_success_i,
        input  req_ready_o, ch_src_addr_o, ch_receiver_list_o, ch_busy_o, ch_timeout_o
    );

endinterface
`default_nettype wire

// File: rtl/back_icon_channel_arbiter_tracker.sv
`default_nettype none
// ============================================================================
// Module   : back_icon_channel_tracker
// Purpose  : One interconnect channel: pending receivers, owner and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module back_icon_channel_tracker
    import back_icon_channel_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    input  wire logic                i_grant,
    input  wire type_icon_arb_req    i_load,
    input  wire logic [RECV_W-1:0]   i_success,
    output logic                     o_busy,
    output type_exec_unit_addr       o_src_addr,
    output logic [RECV_W-1:0]        o_list,
    output logic                     o_timeout
);

    localparam logic [7:0] C_COUNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t              r_state;
    logic [RECV_W-1:0]   r_pending;
    type_exec_unit_addr  r_src;
    logic [7:0]          r_count;
    logic                r_timeout;

    logic                w_hit;
    logic [RECV_W-1:0]   w_next;

    // Only successes for still-pending receivers count as progress.
    assign w_hit  = |(i_success & r_pending);
    assign w_next = r_pending & ~i_success;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_src     <= '0;
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_grant) begin
                        r_state   <= ST_ACTIVE;
                        r_pending <= i_load.receivers;
                        r_src     <= i_load.src_addr;
                        r_count   <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_next == '0) begin
                        r_state   <= ST_IDLE;
                        r_pending <= '0;
                        r_src     <= '0;
                        r_count   <= '0;
                    end else if (!w_hit && (r_count == C_COUNT_LAST)) begin
                        r_state   <= ST_IDLE;
                        r_pending <= '0;
                        r_src     <= '0;
                        r_count   <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_pending <= w_next;
                        r_count   <= w_hit ? 8'd0 : r_count + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy     = (r_state == ST_ACTIVE);
    assign o_src_addr = r_src;
    assign o_list     = r_pending;
    assign o_timeout  = r_timeout;

endmodule
`default_nettype wire

// File: rtl/back_icon_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : back_icon_channel_arbiter
// Purpose  : Round-robin allocation of requesters onto free interconnect channels.
// Revision : 1.0 - initial release
// ============================================================================
module back_icon_channel_arbiter
    import back_icon_channel_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    back_icon_channel_arbiter_if.slave  bus
);

    logic [RR_W-1:0]                              r_rr_ptr;
    logic [NUM_ICON_CHANNELS-1:0]                 w_busy;
    logic [NUM_ICON_CHANNELS-1:0]                 w_timeout;
    logic [NUM_ICON_CHANNELS-1:0]                 w_grant;
    logic [NUM_ICON_CHANNELS-1:0]                 w_avail;
    type_icon_arb_req [NUM_ICON_CHANNELS-1:0]     w_load;
    type_exec_unit_addr [NUM_ICON_CHANNELS-1:0]   w_src;
    logic [NUM_ICON_CHANNELS-1:0][RECV_W-1:0]     w_list;
    logic [NUM_REQUESTERS-1:0]                    w_ready;
    logic [RR_W-1:0]                              w_idx;
    logic [RR_W-1:0]                              w_last;
    logic                                         w_found;
    logic                                         w_any;

    // Requesters in round-robin order each take the lowest channel that was
    // idle at the start of the cycle; empty masks are acked without a channel.
    always_comb begin
        w_ready = '0;
        w_grant = '0;
        w_load  = '0;
        w_avail = ~w_busy;
        w_idx   = '0;
        w_last  = '0;
        w_found = 1'b0;
        w_any   = 1'b0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            w_idx   = rr_index(r_rr_ptr, i);
            w_found = 1'b0;
            if (bus.req_valid_i[w_idx]) begin
                if (bus.req_receivers_i[w_idx] == '0) begin
                    w_ready[w_idx] = 1'b1;
                end else begin
                    for (int c = 0; c < NUM_ICON_CHANNELS; c++) begin
                        if (!w_found && w_avail[c]) begin
                            w_found            = 1'b1;
                            w_avail[c]         = 1'b0;
                            w_grant[c]         = 1'b1;
                            w_load[c].src_addr = bus.req_src_addr_i[w_idx];
                            w_load[c].receivers = type_icon_receivers_list'(bus.req_receivers_i[w_idx]);
                        end
                    end
                    if (w_found) begin
                        w_ready[w_idx] = 1'b1;
                        w_any          = 1'b1;
                        w_last         = w_idx;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= rr_index(w_last, 1);
        end
    end

    generate
        for (genvar g = 0; g < NUM_ICON_CHANNELS; g++) begin : g_ch
            back_icon_channel_tracker #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
            ) u_tracker (
                .clk        (clk),
                .reset_n    (reset_n),
                .i_grant    (w_grant[g]),
                .i_load     (w_load[g]),
                .i_success  (bus.ch_success_i[g]),
                .o_busy     (w_busy[g]),
                .o_src_addr (w_src[g]),
                .o_list     (w_list[g]),
                .o_timeout  (w_timeout[g])
            );
        end
    endgenerate

    assign bus.req_ready_o        = w_ready;
    assign bus.ch_busy_o          = w_busy;
    assign bus.ch_src_addr_o      = w_src;
    assign bus.ch_receiver_list_o = w_list;
    assign bus.ch_timeout_o       = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_back_icon_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_back_icon_channel_arbiter
// Purpose  : Directed vector table plus multi-cycle sequences for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_back_icon_channel_arbiter;
    import back_icon_channel_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    back_icon_channel_arbiter_if u_if();

    back_icon_channel_arbiter #(
        .TIMEOUT_CYCLES (15)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [7:0]  src;
        logic [39:0] recv;
        logic [39:0] succ;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_busy;
        logic [39:0] exp_list;
        logic [7:0]  exp_src;
        logic [3:0]  exp_to;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] v, input logic [7:0] s, input logic [39:0] rc,
                       input logic [39:0] sc, input logic [3:0] er, input logic [3:0] eb,
                       input logic [39:0] el, input logic [7:0] es, input logic [3:0] et);
        vec_t x;
        x.valid = v; x.src = s; x.recv = rc; x.succ = sc;
        x.exp_ready = er; x.exp_busy = eb; x.exp_list = el; x.exp_src = es; x.exp_to = et;
        vecs.push_back(x);
    endtask

    task automatic drive(input logic [3:0] v, input logic [7:0] s, input logic [39:0] rc,
                         input logic [39:0] sc);
        u_if.req_valid_i     = v;
        u_if.req_src_addr_i  = s;
        u_if.req_receivers_i = rc;
        u_if.ch_success_i    = sc;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] er, input logic [3:0] eb,
                           input logic [39:0] el, input logic [7:0] es, input logic [3:0] et);
        chk({tag, ".ready"},   64'(u_if.req_ready_o),        64'(er));
        chk({tag, ".busy"},    64'(u_if.ch_busy_o),          64'(eb));
        chk({tag, ".list"},    64'(u_if.ch_receiver_list_o), 64'(el));
        chk({tag, ".src"},     64'(u_if.ch_src_addr_o),      64'(es));
        chk({tag, ".timeout"}, 64'(u_if.ch_timeout_o),       64'(et));
    endtask

    initial begin
        reset_n = 1'b0;
        drive('0, '0, '0, '0);

        // Vectors: inputs for the cycle, expected comb ready and registered outputs seen in it.
        add(4'b0000, 8'h00, 40'h0, 40'h0, 4'b0000, 4'b0000, 40'h0, 8'h00, 4'b0000);
        add(4'b0001, {2'd0, 2'd0, 2'd0, 2'd2}, {10'h0, 10'h0, 10'h0, 10'h006}, 40'h0,
            4'b0001, 4'b0000, 40'h0, 8'h00, 4'b0000);
        add(4'b0000, 8'h00, 40'h0, {10'h0, 10'h0, 10'h0, 10'h003},
            4'b0000, 4'b0001, {10'h0, 10'h0, 10'h0, 10'h006}, {2'd0, 2'd0, 2'd0, 2'd2}, 4'b0000);
        add(4'b0000, 8'h00, 40'h0, {10'h0, 10'h0, 10'h0, 10'h004},
            4'b0000, 4'b0001, {10'h0, 10'h0, 10'h0, 10'h004}, {2'd0, 2'd0, 2'd0, 2'd2}, 4'b0000);
        add(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, {10'h200, 10'h100, 10'h010, 10'h001}, 40'h0,
            4'b1111, 4'b0000, 40'h0, 8'h00, 4'b0000);
        add(4'b0100, {2'd0, 2'd1, 2'd0, 2'd0}, {10'h0, 10'h020, 10'h0, 10'h0},
            {10'h001, 10'h200, 10'h100, 10'h010},
            4'b0000, 4'b1111, {10'h001, 10'h200, 10'h100, 10'h010}, {2'd0, 2'd3, 2'd2, 2'd1}, 4'b0000);
        add(4'b0110, {2'd0, 2'd1, 2'd0, 2'd0}, {10'h0, 10'h020, 10'h0, 10'h0}, 40'h0,
            4'b0110, 4'b0000, 40'h0, 8'h00, 4'b0000);
        add(4'b1010, {2'd0, 2'd0, 2'd3, 2'd0}, {10'h080, 10'h0, 10'h040, 10'h0},
            {10'h0, 10'h0, 10'h0, 10'h020},
            4'b1010, 4'b0001, {10'h0, 10'h0, 10'h0, 10'h020}, {2'd0, 2'd0, 2'd0, 2'd1}, 4'b0000);
        add(4'b1101, {2'd3, 2'd2, 2'd0, 2'd0}, {10'h004, 10'h002, 10'h0, 10'h001},
            {10'h0, 10'h040, 10'h080, 10'h0},
            4'b1100, 4'b0110, {10'h0, 10'h040, 10'h080, 10'h0}, {2'd0, 2'd3, 2'd0, 2'd0}, 4'b0000);
        add(4'b0001, 8'h00, {10'h0, 10'h0, 10'h0, 10'h001}, {10'h004, 10'h0, 10'h0, 10'h002},
            4'b0001, 4'b1001, {10'h004, 10'h0, 10'h0, 10'h002}, {2'd3, 2'd0, 2'd0, 2'd2}, 4'b0000);
        add(4'b0000, 8'h00, 40'h0, {10'h0, 10'h0, 10'h001, 10'h0},
            4'b0000, 4'b0010, {10'h0, 10'h0, 10'h001, 10'h0}, 8'h00, 4'b0000);
        add(4'b0000, 8'h00, 40'h0, 40'h0, 4'b0000, 4'b0000, 40'h0, 8'h00, 4'b0000);

        repeat (2) @(negedge clk);
        #1 chk_all("reset", 4'b0000, 4'b0000, 40'h0, 8'h00, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].src, vecs[i].recv, vecs[i].succ);
            #1 chk_all($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_busy,
                       vecs[i].exp_list, vecs[i].exp_src, vecs[i].exp_to);
            @(negedge clk);
        end

        // Contention: every channel busy, completing channel reused only next cycle.
        drive(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, {10'h008, 10'h004, 10'h002, 10'h001}, 40'h0);
        #1 chk("cont.fill.ready", 64'(u_if.req_ready_o), 64'hF);
        @(negedge clk);
        drive(4'b1010, {2'd3, 2'd0, 2'd1, 2'd0}, {10'h0C0, 10'h0, 10'h030, 10'h0},
              {10'h0, 10'h008, 10'h0, 10'h0});
        #1 chk("cont.t.busy", 64'(u_if.ch_busy_o), 64'hF);
        chk("cont.t.list2", 64'(u_if.ch_receiver_list_o[2]), 64'h008);
        chk("cont.t.ready", 64'(u_if.req_ready_o), 64'h0);
        @(negedge clk);
        u_if.ch_success_i = '0;
        #1 chk("cont.t1.busy", 64'(u_if.ch_busy_o), 64'hB);
        chk("cont.t1.ready", 64'(u_if.req_ready_o), 64'h2);
        @(negedge clk);
        u_if.req_valid_i = 4'b1000;
        u_if.ch_success_i[0] = 10'h002;
        #1 chk("cont.t2.busy", 64'(u_if.ch_busy_o), 64'hF);
        chk("cont.t2.list2", 64'(u_if.ch_receiver_list_o[2]), 64'h030);
        chk("cont.t2.src2", 64'(u_if.ch_src_addr_o[2]), 64'h1);
        chk("cont.t2.ready", 64'(u_if.req_ready_o), 64'h0);
        @(negedge clk);
        u_if.ch_success_i = '0;
        #1 chk("cont.t3.busy", 64'(u_if.ch_busy_o), 64'hE);
        chk("cont.t3.ready", 64'(u_if.req_ready_o), 64'h8);
        @(negedge clk);
        u_if.req_valid_i = '0;
        u_if.ch_success_i[3] = 10'h001;
        #1 chk("cont.t4.list0", 64'(u_if.ch_receiver_list_o[0]), 64'h0C0);
        chk("cont.t4.src0", 64'(u_if.ch_src_addr_o[0]), 64'h3);
        @(negedge clk);
        u_if.ch_success_i = '0;
        #1 chk("rst.pre.busy", 64'(u_if.ch_busy_o), 64'h7);

        // Asynchronous reset with three channels active.
        #1 reset_n = 1'b0;
        #1 chk_all("rst.async", 4'b0000, 4'b0000, 40'h0, 8'h00, 4'b0000);
        @(negedge clk);
        #1 chk("rst.hold.timeout", 64'(u_if.ch_timeout_o), 64'h0);
        reset_n = 1'b1;
        @(negedge clk);
        #1 chk_all("rst.after", 4'b0000, 4'b0000, 40'h0, 8'h00, 4'b0000);
        @(negedge clk);

        // Timeout: 15 busy cycles with no success, then a one-cycle pulse.
        drive(4'b0001, {2'd0, 2'd0, 2'd0, 2'd1}, {10'h0, 10'h0, 10'h0, 10'h001}, 40'h0);
        #1 chk("to.grant.ready", 64'(u_if.req_ready_o), 64'h1);
        @(negedge clk);
        drive('0, '0, '0, '0);
        for (int k = 1; k <= 15; k++) begin
            #1 chk($sformatf("to.busy%0d", k), 64'({u_if.ch_busy_o, u_if.ch_timeout_o}), 64'h10);
            @(negedge clk);
        end
        drive(4'b0010, {2'd0, 2'd0, 2'd2, 2'd0}, {10'h0, 10'h0, 10'h003, 10'h0}, 40'h0);
        #1 chk("to.release.busy", 64'(u_if.ch_busy_o), 64'h0);
        chk("to.release.pulse", 64'(u_if.ch_timeout_o), 64'h1);
        chk("to.realloc.ready", 64'(u_if.req_ready_o), 64'h2);
        @(negedge clk);
        drive('0, '0, '0, '0);
        #1 chk("to.pulse.end", 64'(u_if.ch_timeout_o), 64'h0);
        chk("to.realloc.list0", 64'(u_if.ch_receiver_list_o[0]), 64'h003);

        // Late in-pending success at count 14 saves the channel.
        for (int k = 0; k < 15; k++) begin
            u_if.ch_success_i[0] = (k == 14) ? 10'h001 : 10'h000;
            if (k == 14) #1 chk("late.busy14", 64'(u_if.ch_busy_o), 64'h1);
            @(negedge clk);
        end
        // Success bits outside pending at count 14 do not save it.
        for (int k = 0; k < 15; k++) begin
            u_if.ch_success_i[0] = (k == 14) ? 10'h300 : 10'h000;
            if (k == 0) begin
                #1 chk("late.list", 64'(u_if.ch_receiver_list_o[0]), 64'h002);
                chk("late.nopulse", 64'({u_if.ch_busy_o, u_if.ch_timeout_o}), 64'h10);
            end
            @(negedge clk);
        end
        u_if.ch_success_i = '0;
        #1 chk("ign.busy", 64'(u_if.ch_busy_o), 64'h0);
        chk("ign.pulse", 64'(u_if.ch_timeout_o), 64'h1);
        @(negedge clk);
        #1 chk("ign.pulse.end", 64'(u_if.ch_timeout_o), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
